fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and instruction memory.
// The fetch stage drives request/address; memory answers with ack/data,
// possibly in the same cycle the request is first raised.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, issues instruction-memory
// reads over a req/ack handshake and loads the IF/ID pipeline register.
// A one-entry skid buffer absorbs a word that returns while decode is stalled.
// A redirect that arrives while a read is still outstanding cannot drop the
// request, so the stage drains that read and throws its data away.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic [1:0]    i_pcsrc,
  input  logic [31:0]   i_nextpc,
  input  logic [31:0]   i_epc,
  fetch_stage_if.master imem,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_ifid_pc4,
  output logic [31:0]   o_ifid_instr,
  output logic          o_ifid_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        req_r, req_s;
  logic [31:0] pend_pc_r, pend_pc_s;
  logic        discard_r, discard_s;
  logic        skid_full_r, skid_full_s;
  logic [31:0] skid_pc4_r, skid_pc4_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_s;
  logic [31:0] ifid_instr_r, ifid_instr_s;
  logic        ifid_valid_r, ifid_valid_s;

  logic        redirect_s;
  logic        ack_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Raw redirect target chosen by the PC-source code (00 never redirects).
  function automatic logic [31:0] sel_target(input logic [1:0]  src,
                                             input logic [31:0] nextpc,
                                             input logic [31:0] epc,
                                             input logic [31:0] exc);
    logic [31:0] t;
    case (src)
      2'b01:   t = nextpc;
      2'b10:   t = epc;
      2'b11:   t = exc;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  // Decode the redirect request and qualify ack with an outstanding request.
  always_comb begin
    redirect_s = (i_pcsrc != 2'b00);
    target_s   = sel_target(i_pcsrc, i_nextpc, i_epc, EXC_VECTOR) & 32'hFFFF_FFFC;
    ack_s      = imem.imem_ack & req_r;
    pc_plus4_s = pc_r + 32'd4;
  end

  // Next-state and next-register values: redirect beats stall beats delivery.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_s        = req_r;
    pend_pc_s    = pend_pc_r;
    discard_s    = discard_r;
    skid_full_s  = skid_full_r;
    skid_pc4_s   = skid_pc4_r;
    skid_instr_s = skid_instr_r;
    ifid_pc4_s   = ifid_pc4_r;
    ifid_instr_s = ifid_instr_r;
    ifid_valid_s = ifid_valid_r;

    case (state_r)
      ST_FETCH: begin
        if (redirect_s) begin
          ifid_valid_s = 1'b0;
          ifid_instr_s = 32'h0000_0000;
          skid_full_s  = 1'b0;
          if (req_r && !ack_s) begin
            // Read still in flight: keep req/addr stable and drain it.
            pend_pc_s = target_s;
            discard_s = 1'b1;
            req_s     = 1'b1;
            state_s   = ST_DRAIN;
          end else begin
            // Nothing outstanding (or it completed now): jump immediately.
            pc_s      = target_s;
            discard_s = 1'b0;
            req_s     = 1'b1;
            state_s   = ST_FETCH;
          end
        end else if (ack_s) begin
          pc_s = pc_plus4_s;
          if (i_stall) begin
            skid_full_s  = 1'b1;
            skid_pc4_s   = pc_plus4_s;
            skid_instr_s = imem.imem_data;
            req_s        = 1'b0;
            state_s      = ST_HOLD;
          end else begin
            ifid_pc4_s   = pc_plus4_s;
            ifid_instr_s = imem.imem_data;
            ifid_valid_s = 1'b1;
            req_s        = 1'b1;
          end
        end else begin
          // Waiting on memory (or first cycle out of reset): keep requesting.
          req_s = 1'b1;
          if (!i_stall) begin
            ifid_valid_s = 1'b0;
          end else begin
            ifid_valid_s = ifid_valid_r;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_s) begin
          ifid_valid_s = 1'b0;
          ifid_instr_s = 32'h0000_0000;
          skid_full_s  = 1'b0;
          pc_s         = target_s;
          req_s        = 1'b1;
          state_s      = ST_FETCH;
        end else if (!i_stall) begin
          ifid_pc4_s   = skid_pc4_r;
          ifid_instr_s = skid_instr_r;
          ifid_valid_s = skid_full_r;
          skid_full_s  = 1'b0;
          req_s        = 1'b1;
          state_s      = ST_FETCH;
        end else begin
          req_s = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (redirect_s) begin
          ifid_instr_s = 32'h0000_0000;
        end else begin
          ifid_instr_s = ifid_instr_r;
        end
        if (ack_s) begin
          // The returning word belongs to the abandoned path and is dropped.
          ifid_valid_s = ifid_valid_r & ~discard_r;
          pc_s         = redirect_s ? target_s : pend_pc_r;
          discard_s    = 1'b0;
          req_s        = 1'b1;
          state_s      = ST_FETCH;
        end else begin
          ifid_valid_s = 1'b0;
          if (redirect_s) begin
            pend_pc_s = target_s;
          end else begin
            pend_pc_s = pend_pc_r;
          end
        end
      end

      default: begin
        req_s   = 1'b0;
        state_s = ST_FETCH;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      req_r        <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
      discard_r    <= 1'b0;
      skid_full_r  <= 1'b0;
      skid_pc4_r   <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_instr_r <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_r        <= req_s;
      pend_pc_r    <= pend_pc_s;
      discard_r    <= discard_s;
      skid_full_r  <= skid_full_s;
      skid_pc4_r   <= skid_pc4_s;
      skid_instr_r <= skid_instr_s;
      ifid_pc4_r   <= ifid_pc4_s;
      ifid_instr_r <= ifid_instr_s;
      ifid_valid_r <= ifid_valid_s;
    end
  end

  assign o_pc           = pc_r;
  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign o_ifid_pc4     = ifid_pc4_r;
  assign o_ifid_instr   = ifid_instr_r;
  assign o_ifid_valid   = ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A transaction-level model tracks the PC,
// whether a stale read is being drained, a queue of words held back by a
// stall, and the IF/ID contents; it is compared against the DUT every cycle.
// Literal checks pin the model at the interesting points.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst, stall, ack_cmd;
  logic [1:0]  pcsrc;
  logic [31:0] nextpc, epc;
  logic [31:0] o_pc, o_ifid_pc4, o_ifid_instr;
  logic        o_ifid_valid;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // model state
  logic [31:0] m_pc, m_tgt, m_pc4, m_ins;
  logic        m_req, m_stale, m_v;
  logic [63:0] held[$];

  always #5 clk = ~clk;

  fetch_stage_if bus();
  // memory: acks only while a request is up; data = address ^ K
  assign bus.imem_ack  = ack_cmd & bus.imem_req;
  assign bus.imem_data = bus.imem_addr ^ K;

  fetch_stage dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stall     (stall),
    .i_pcsrc     (pcsrc),
    .i_nextpc    (nextpc),
    .i_epc       (epc),
    .imem        (bus),
    .o_pc        (o_pc),
    .o_ifid_pc4  (o_ifid_pc4),
    .o_ifid_instr(o_ifid_instr),
    .o_ifid_valid(o_ifid_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic        redir, acked;
    logic [31:0] raw, tgt;
    if (rst) begin
      m_pc = 32'h0; m_req = 1'b0; m_stale = 1'b0; m_tgt = 32'h0;
      m_v = 1'b0; m_pc4 = 32'h0; m_ins = 32'h0;
      held.delete();
    end else begin
      redir = (pcsrc != 2'b00);
      raw   = (pcsrc == 2'b01) ? nextpc : (pcsrc == 2'b10) ? epc : 32'h0000_0180;
      tgt   = {raw[31:2], 2'b00};
      acked = m_req && ack_cmd;
      if (redir) begin
        m_v = 1'b0; m_ins = 32'h0;
        held.delete();
        if (acked || !m_req) begin
          m_pc = tgt; m_stale = 1'b0; m_req = 1'b1;
        end else begin
          m_stale = 1'b1; m_tgt = tgt;
        end
      end else if (m_stale) begin
        if (acked) begin
          m_pc = m_tgt; m_stale = 1'b0;
        end
      end else if (held.size() != 0) begin
        if (!stall) begin
          {m_pc4, m_ins} = held.pop_front();
          m_v = 1'b1; m_req = 1'b1;
        end
      end else if (acked) begin
        if (stall) begin
          held.push_back({m_pc + 32'd4, m_pc ^ K});
          m_req = 1'b0;
        end else begin
          m_pc4 = m_pc + 32'd4; m_ins = m_pc ^ K; m_v = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else begin
        if (!stall) m_v = 1'b0;
        m_req = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    chk("pc",    o_pc, m_pc);
    chk("addr",  bus.imem_addr, m_pc);
    chk("req",   {31'd0, bus.imem_req}, {31'd0, m_req});
    chk("valid", {31'd0, o_ifid_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("pc4",   o_ifid_pc4, m_pc4);
      chk("instr", o_ifid_instr, m_ins);
    end
  endtask

  // one clock: apply inputs, compare at the falling edge, advance model at the rising edge
  task automatic step(input logic r, input logic s, input logic [1:0] src,
                      input logic [31:0] np, input logic [31:0] ep, input logic a);
    rst = r; stall = s; pcsrc = src; nextpc = np; epc = ep; ack_cmd = a;
    @(negedge clk);
    if (chk_en) compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pcsrc = 2'b00; nextpc = 32'h0; epc = 32'h0; ack_cmd = 1'b0;

    // reset (pcsrc must be ignored while in reset)
    step(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_ifid_valid}, 32'd0);
    chk("rst_pc4", o_ifid_pc4, 32'h0);
    chk("rst_instr", o_ifid_instr, 32'h0);

    // zero-wait sequential fetch
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("req_rise", {31'd0, bus.imem_req}, 32'd1);
    chk("addr0", bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("pc4_a", o_ifid_pc4, 32'd4);
    chk("instr_a", o_ifid_instr, 32'hA5A5_A5A5);
    chk("valid_a", {31'd0, o_ifid_valid}, 32'd1);
    chk("addr4", bus.imem_addr, 32'd4);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("pc4_b", o_ifid_pc4, 32'd8);
    chk("instr_b", o_ifid_instr, 32'hA5A5_A5A1);
    chk("addr8", bus.imem_addr, 32'd8);

    // ack under stall at pc=8, stall held three cycles
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_pc4", o_ifid_pc4, 32'd8);
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("hold_req3", {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    chk("skid_pc4", o_ifid_pc4, 32'd12);
    chk("skid_instr", o_ifid_instr, 32'hA5A5_A5AD);
    chk("skid_addr", bus.imem_addr, 32'd12);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("addr16", bus.imem_addr, 32'd16);

    // two wait states; redirect to 0x40 the cycle after req at 16
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 1'b0);
    chk("drain_addr", bus.imem_addr, 32'd16);
    chk("drain_valid", {31'd0, o_ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("redir_addr", bus.imem_addr, 32'h40);
    chk("redir_valid", {31'd0, o_ifid_valid}, 32'd0);

    // latest redirect wins while draining
    step(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("exc_addr", bus.imem_addr, 32'h180);
    chk("exc_valid", {31'd0, o_ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("exc_pc4", o_ifid_pc4, 32'h184);
    chk("exc_instr", o_ifid_instr, 32'hA5A5_A425);

    // eret together with stall: flush wins, target aligned
    step(1'b0, 1'b1, 2'b10, 32'h0, 32'h1003, 1'b1);
    chk("eret_valid", {31'd0, o_ifid_valid}, 32'd0);
    chk("eret_instr", o_ifid_instr, 32'h0);
    chk("eret_addr", bus.imem_addr, 32'h1000);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("eret_fetch", o_ifid_instr, 32'hA5A5_B5A5);

    // wrap at the top of the address space
    step(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("wrap_pc4", o_ifid_pc4, 32'h0);
    chk("wrap_instr", o_ifid_instr, 32'h5A5A_5A59);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // reset in the middle of a drain; the late ack must not deliver
    step(1'b0, 1'b0, 2'b01, 32'h200, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, o_ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    chk("post_rst_valid", {31'd0, o_ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("post_rst_pc4", o_ifid_pc4, 32'd4);

    // redirect out of a held (stalled) word
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 2'b01, 32'h80, 32'h0, 1'b0);
    chk("hold_redir_addr", bus.imem_addr, 32'h80);
    chk("hold_redir_valid", {31'd0, o_ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("hold_redir_pc4", o_ifid_pc4, 32'h84);

    @(negedge clk);
    compare_model();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
